// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: FSM states, opcodes
// and per-class execute lengths.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 5;
    localparam int STEP_W   = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        FETCH1,
        FETCH2,
        DECODE,
        EXEC,
        HALT
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_LD   = 5'h00;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'h02;
    localparam logic [OPCODE_W-1:0] OP_BR   = 5'h12;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'h1E;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'h1F;

    localparam logic [STEP_W-1:0] LEN_BR   = 3'd2;
    localparam logic [STEP_W-1:0] LEN_MEM  = 3'd4;
    localparam logic [STEP_W-1:0] LEN_ALU  = 3'd3;
    localparam logic [STEP_W-1:0] MEM_STEP = 3'd2;
    localparam logic [STEP_W-1:0] BR_STEP  = 3'd1;

    function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic [STEP_W-1:0] last_step(input logic [OPCODE_W-1:0] op);
        if (op == OP_BR)
            return LEN_BR - 3'd1;
        else if (is_mem_op(op))
            return LEN_MEM - 3'd1;
        else
            return LEN_ALU - 3'd1;
    endfunction

endpackage

// File: rtl/ctrl_strobe_decode.sv
// Combinational Moore decode of the sequencer state into datapath strobes.
module ctrl_strobe_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_W,
    parameter int EXEC_STEPS_W = STEP_W
) (
    input  state_t                  state,
    input  logic [EXEC_STEPS_W-1:0] exec_step,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    branch_taken,
    output logic                    pc_enable,
    output logic                    inc_pc,
    output logic                    pc_in,
    output logic                    pc_out_en,
    output logic                    mar_in,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    mdr_in,
    output logic                    mdr_out_en,
    output logic                    ir_in,
    output logic                    running,
    output logic                    instr_done
);

    always_comb begin
        pc_enable  = 1'b0;
        inc_pc     = 1'b0;
        pc_in      = 1'b0;
        pc_out_en  = 1'b0;
        mar_in     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mdr_in     = 1'b0;
        mdr_out_en = 1'b0;
        ir_in      = 1'b0;
        instr_done = 1'b0;
        running    = (state != IDLE) && (state != HALT);

        case (state)
            FETCH0: begin
                pc_out_en = 1'b1;
                mar_in    = 1'b1;
                pc_enable = 1'b1;
                inc_pc    = 1'b1;
            end
            FETCH1: begin
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            FETCH2: begin
                mdr_out_en = 1'b1;
                ir_in      = 1'b1;
            end
            DECODE: instr_done = (opcode == OP_NOP);
            EXEC: begin
                // Branch target loads only when the CON flag is set; inc_pc stays low here
                if (opcode == OP_BR && exec_step == BR_STEP && branch_taken) begin
                    pc_enable = 1'b1;
                    pc_in     = 1'b1;
                end
                if (opcode == OP_LD && exec_step == MEM_STEP) begin
                    mem_read = 1'b1;
                    mdr_in   = 1'b1;
                end
                if (opcode == OP_ST && exec_step == MEM_STEP)
                    mem_write = 1'b1;
                instr_done = (exec_step == last_step(opcode));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM with memory handshake and
// halt/run control; strobes come from ctrl_strobe_decode.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_W,
    parameter int EXEC_STEPS_W = STEP_W
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    run,
    input  logic                    stop,
    input  logic [OPCODE_WIDTH-1:0] ir_opcode,
    input  logic                    branch_taken,
    input  logic                    mem_ready,
    output logic                    pc_enable,
    output logic                    inc_pc,
    output logic                    pc_in,
    output logic                    pc_out_en,
    output logic                    mar_in,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    mdr_in,
    output logic                    mdr_out_en,
    output logic                    ir_in,
    output logic [EXEC_STEPS_W-1:0] exec_step,
    output logic                    running,
    output logic                    instr_done
);

    state_t                  state;
    state_t                  state_next;
    logic [EXEC_STEPS_W-1:0] step_next;
    logic                    stop_pending;
    logic                    pending_next;
    logic                    boundary;
    logic                    mem_wait;

    assign mem_wait = (exec_step == MEM_STEP) && is_mem_op(ir_opcode) && !mem_ready;

    always_ff @(posedge clock) begin
        if (clear) begin
            state        <= IDLE;
            exec_step    <= '0;
            stop_pending <= 1'b0;
        end else begin
            state        <= state_next;
            exec_step    <= step_next;
            stop_pending <= pending_next;
        end
    end

    always_comb begin
        state_next   = state;
        step_next    = exec_step;
        pending_next = stop_pending | stop;
        boundary     = 1'b0;

        case (state)
            IDLE: begin
                if (run && !stop) begin
                    state_next   = FETCH0;
                    pending_next = 1'b0;
                end
            end
            FETCH0: state_next = FETCH1;
            FETCH1: if (mem_ready) state_next = FETCH2;
            FETCH2: state_next = DECODE;
            DECODE: begin
                if (ir_opcode == OP_HALT) begin
                    state_next = HALT;
                end else if (ir_opcode == OP_NOP) begin
                    boundary = 1'b1;
                end else begin
                    state_next = EXEC;
                    step_next  = '0;
                end
            end
            EXEC: begin
                // A memory step freezes the counter until the handshake completes
                if (mem_wait)
                    step_next = exec_step;
                else if (exec_step == last_step(ir_opcode))
                    boundary = 1'b1;
                else
                    step_next = exec_step + EXEC_STEPS_W'(1);
            end
            HALT: begin
                if (run) begin
                    state_next   = FETCH0;
                    pending_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        // A stop arriving on the boundary cycle itself still halts here
        if (boundary) begin
            step_next = '0;
            if (stop_pending || stop) begin
                state_next   = HALT;
                pending_next = 1'b0;
            end else begin
                state_next = FETCH0;
            end
        end
    end

    ctrl_strobe_decode #(
        .OPCODE_WIDTH(OPCODE_WIDTH),
        .EXEC_STEPS_W(EXEC_STEPS_W)
    ) u_strobe_decode (
        .state       (state),
        .exec_step   (exec_step),
        .opcode      (ir_opcode),
        .branch_taken(branch_taken),
        .pc_enable   (pc_enable),
        .inc_pc      (inc_pc),
        .pc_in       (pc_in),
        .pc_out_en   (pc_out_en),
        .mar_in      (mar_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mdr_in      (mdr_in),
        .mdr_out_en  (mdr_out_en),
        .ir_in       (ir_in),
        .running     (running),
        .instr_done  (instr_done)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-cycle plan of inputs and
// expected output vectors built from instruction-level timing.
module tb_control_sequencer;

    localparam logic [4:0] T_LD   = 5'h00;
    localparam logic [4:0] T_ST   = 5'h02;
    localparam logic [4:0] T_BR   = 5'h12;
    localparam logic [4:0] T_NOP  = 5'h1E;
    localparam logic [4:0] T_HALT = 5'h1F;

    // Output vector: {pc_enable, inc_pc, pc_in, pc_out_en, mar_in, mem_read, mem_write,
    //                 mdr_in, mdr_out_en, ir_in, running, instr_done, exec_step[2:0]}
    localparam logic [14:0] B_PCE    = 15'h4000;
    localparam logic [14:0] B_INC    = 15'h2000;
    localparam logic [14:0] B_PCIN   = 15'h1000;
    localparam logic [14:0] B_PCOUT  = 15'h0800;
    localparam logic [14:0] B_MARIN  = 15'h0400;
    localparam logic [14:0] B_MRD    = 15'h0200;
    localparam logic [14:0] B_MWR    = 15'h0100;
    localparam logic [14:0] B_MDRIN  = 15'h0080;
    localparam logic [14:0] B_MDROUT = 15'h0040;
    localparam logic [14:0] B_IRIN   = 15'h0020;
    localparam logic [14:0] B_RUN    = 15'h0010;
    localparam logic [14:0] B_DONE   = 15'h0008;

    localparam logic [14:0] V_OFF = 15'h0000;
    localparam logic [14:0] V_F0  = B_PCE | B_INC | B_PCOUT | B_MARIN | B_RUN;
    localparam logic [14:0] V_F1  = B_MRD | B_MDRIN | B_RUN;
    localparam logic [14:0] V_F2  = B_MDROUT | B_IRIN | B_RUN;

    typedef struct {
        logic        clr;
        logic        run;
        logic        stop;
        logic        mr;
        logic        br;
        logic [4:0]  op;
        logic [14:0] exp;
        string       tag;
    } item_t;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic        stop;
    logic [4:0]  ir_opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        pc_enable, inc_pc, pc_in, pc_out_en, mar_in, mem_read, mem_write;
    logic        mdr_in, mdr_out_en, ir_in, running, instr_done;
    logic [2:0]  exec_step;
    logic [14:0] observed;

    int          checks   = 0;
    int          failures = 0;
    item_t       plan_q[$];
    logic [14:0] sb_q[$];
    string       sb_tag_q[$];

    control_sequencer dut (
        .clock       (clock),
        .clear       (clear),
        .run         (run),
        .stop        (stop),
        .ir_opcode   (ir_opcode),
        .branch_taken(branch_taken),
        .mem_ready   (mem_ready),
        .pc_enable   (pc_enable),
        .inc_pc      (inc_pc),
        .pc_in       (pc_in),
        .pc_out_en   (pc_out_en),
        .mar_in      (mar_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mdr_in      (mdr_in),
        .mdr_out_en  (mdr_out_en),
        .ir_in       (ir_in),
        .exec_step   (exec_step),
        .running     (running),
        .instr_done  (instr_done)
    );

    always #5 clock = ~clock;

    assign observed = {pc_enable, inc_pc, pc_in, pc_out_en, mar_in, mem_read, mem_write,
                       mdr_in, mdr_out_en, ir_in, running, instr_done, exec_step};

    task automatic checkOutput(input string tag, input logic [14:0] actual, input logic [14:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: outputs=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic addCycle(input logic clr, input logic run_i, input logic stop_i, input logic mr,
                            input logic br, input logic [4:0] op, input logic [14:0] e, input string tag);
        item_t it;
        it.clr = clr; it.run = run_i; it.stop = stop_i; it.mr = mr;
        it.br = br; it.op = op; it.exp = e; it.tag = tag;
        plan_q.push_back(it);
    endtask

    task automatic addIdle(input int n, input logic clr, input logic run_i, input logic stop_i, input string tag);
        for (int i = 0; i < n; i++)
            addCycle(clr, run_i, stop_i, 1'($urandom_range(0, 1)), 1'b0, 5'h00, V_OFF, tag);
    endtask

    task automatic instrCycle(input logic mr, input logic [14:0] e, input logic [4:0] op, input logic br,
                              input int stop_idx, input string name, inout int k);
        addCycle(1'b0, 1'b0, (k == stop_idx), mr, br, op, e, $sformatf("%s.c%0d", name, k));
        k++;
    endtask

    // Expected per-cycle trace of one instruction from FETCH0 up to its last cycle
    task automatic genInstr(input logic [4:0] op, input int fetch_wait, input int exec_wait,
                            input logic br, input int stop_idx, input string name);
        int          k = 0;
        int          len;
        logic [14:0] e;
        instrCycle(1'($urandom_range(0, 1)), V_F0, op, br, stop_idx, name, k);
        for (int i = 0; i < fetch_wait; i++)
            instrCycle(1'b0, V_F1, op, br, stop_idx, name, k);
        instrCycle(1'b1, V_F1, op, br, stop_idx, name, k);
        instrCycle(1'($urandom_range(0, 1)), V_F2, op, br, stop_idx, name, k);
        instrCycle(1'($urandom_range(0, 1)), (op == T_NOP) ? (B_RUN | B_DONE) : B_RUN,
                   op, br, stop_idx, name, k);
        if (op != T_HALT && op != T_NOP) begin
            len = (op == T_BR) ? 2 : ((op == T_LD || op == T_ST) ? 4 : 3);
            for (int s = 0; s < len; s++) begin
                e = B_RUN | 15'(s);
                if (s == len - 1) e = e | B_DONE;
                if (op == T_BR && s == 1 && br) e = e | B_PCE | B_PCIN;
                if ((op == T_LD || op == T_ST) && s == 2) begin
                    e = e | ((op == T_LD) ? (B_MRD | B_MDRIN) : B_MWR);
                    for (int i = 0; i < exec_wait; i++)
                        instrCycle(1'b0, e, op, br, stop_idx, name, k);
                    instrCycle(1'b1, e, op, br, stop_idx, name, k);
                end else begin
                    instrCycle(1'($urandom_range(0, 1)), e, op, br, stop_idx, name, k);
                end
            end
        end
    endtask

    task automatic applyStimulus(input item_t it);
        clear        = it.clr;
        run          = it.run;
        stop         = it.stop;
        mem_ready    = it.mr;
        branch_taken = it.br;
        ir_opcode    = it.op;
        sb_q.push_back(it.exp);
        sb_tag_q.push_back(it.tag);
    endtask

    task automatic buildPlan();
        addIdle(2, 1'b1, 1'b0, 1'b0, "clear");
        addIdle(2, 1'b0, 1'b0, 1'b0, "idle");
        addIdle(1, 1'b0, 1'b1, 1'b1, "idle_run_stop");
        addIdle(1, 1'b0, 1'b0, 1'b0, "idle_stayed");
        addIdle(1, 1'b1, 1'b0, 1'b0, "reclear");
        addIdle(1, 1'b0, 1'b0, 1'b0, "idle2");
        addIdle(1, 1'b0, 1'b1, 1'b0, "run_from_idle");
        addCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h03, V_F0, "alu03.c0");
        addCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h03, V_F1, "alu03.c1");
        addCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h03, V_F2, "alu03.c2");
        addCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h03, B_RUN, "alu03.c3");
        addCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h03, B_RUN | 15'd0, "alu03.c4");
        addCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h03, B_RUN | 15'd1, "alu03.c5");
        addCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h03, B_RUN | B_DONE | 15'd2, "alu03.c6");
        genInstr(T_LD, 3, 3, 1'b0, -1, "ld_wait");
        genInstr(T_ST, 1, 2, 1'b0, -1, "st_wait");
        genInstr(T_BR, 0, 0, 1'b1, -1, "br_taken");
        genInstr(T_BR, 0, 0, 1'b0, -1, "br_not");
        genInstr(T_NOP, 2, 0, 1'b0, -1, "nop");
        genInstr(5'h07, 0, 0, 1'b0, 5, "alu_stop_mid");
        addIdle(2, 1'b0, 1'b0, 1'b0, "halt1");
        addIdle(1, 1'b0, 1'b1, 1'b0, "run_from_halt1");
        genInstr(5'h0A, 0, 0, 1'b0, 6, "alu_stop_edge");
        addIdle(1, 1'b0, 1'b0, 1'b0, "halt2");
        addIdle(1, 1'b0, 1'b1, 1'b0, "run_from_halt2");
        genInstr(T_LD, 0, 3, 1'b0, 6, "ld_stop_wait");
        addIdle(1, 1'b0, 1'b0, 1'b0, "halt3");
        addIdle(1, 1'b0, 1'b1, 1'b0, "run_from_halt3");
        genInstr(T_NOP, 0, 0, 1'b0, 3, "nop_stop");
        addIdle(1, 1'b0, 1'b0, 1'b0, "halt4");
        addIdle(1, 1'b0, 1'b1, 1'b0, "run_from_halt4");
        // Clear mid-fetch with a pending stop: both must be forgotten
        addCycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h04, V_F0, "clr_mid.f0");
        addCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h04, V_F1, "clr_mid.f1");
        addCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h04, V_F1, "clr_mid.f1clr");
        addIdle(2, 1'b0, 1'b0, 1'b0, "post_clear");
        addIdle(1, 1'b0, 1'b1, 1'b0, "run_after_clear");
        genInstr(5'h05, 0, 0, 1'b0, -1, "alu_after_clear");
        genInstr(T_HALT, 1, 0, 1'b0, -1, "op_halt");
        addIdle(2, 1'b0, 1'b0, 1'b0, "halted");
        addIdle(1, 1'b0, 1'b1, 1'b0, "run_from_halted");
        genInstr(T_ST, 0, 0, 1'b0, -1, "st_fast");
        addCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h00, V_F0, "final_fetch0");
    endtask

    initial begin
        item_t it;
        clear        = 1'b1;
        run          = 1'b0;
        stop         = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        ir_opcode    = 5'h00;
        buildPlan();
        repeat (2) @(posedge clock);
        while (plan_q.size() > 0) begin
            it = plan_q.pop_front();
            @(posedge clock);
            #1;
            applyStimulus(it);
            @(negedge clock);
            checkOutput(sb_tag_q.pop_front(), observed, sb_q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
